// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if
// Operand/result bundle for the multi-precision add sequencer.
//   in_valid/in_ready : operand handshake (a, b, cin, and sub when MP_ADD_SUB_EN)
//   out_valid/out_ready : result handshake (sum, cout)
// Optional feature macro: MP_ADD_SUB_EN adds the sub select signal.
// master: producer/consumer side (testbench or upstream logic)
// slave : sequencer side
interface mp_add_seq_if #(
   parameter int unsigned NBYTES = 4
);
   localparam int unsigned W = 8 * NBYTES;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
`ifdef MP_ADD_SUB_EN
   logic          sub;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;

   modport master (
`ifdef MP_ADD_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
`ifdef MP_ADD_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq
// Multi-precision add sequencer: one 8-bit add-with-carry slice stepped
// LSB-first across NBYTES-byte operands, one byte per clock.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : mp_add_seq_if.slave (operand handshake in, result handshake out)
// Parameter NBYTES : operand width in bytes, 1..16.
// Optional feature macro: MP_ADD_SUB_EN (subtract select, a - b - cin).
module mp_add_seq #(
   parameter int unsigned NBYTES = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   mp_add_seq_if.slave    bus
);
   localparam int unsigned W    = 8 * NBYTES;
   localparam int unsigned CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_carry, w_carry_nxt;
   logic [W-1:0]    r_a, w_a_nxt;
   logic [W-1:0]    r_b, w_b_nxt;
   logic [W-1:0]    r_acc, w_acc_nxt;
   logic [W-1:0]    r_sum, w_sum_nxt;
   logic            r_cout, w_cout_nxt;
   logic            r_in_ready;
   logic            r_out_valid;
`ifdef MP_ADD_SUB_EN
   logic            r_sub, w_sub_nxt;
`endif

   logic [7:0]      w_b_byte;
   logic [8:0]      w_slice;
   logic [W-1:0]    w_acc_shift;

   // B byte into the slice, inverted when subtracting
`ifdef MP_ADD_SUB_EN
   assign w_b_byte = r_b[7:0] ^ {8{r_sub}};
`else
   assign w_b_byte = r_b[7:0];
`endif

   // 8-bit add-with-carry slice
   assign w_slice = 9'(r_a[7:0]) + 9'(w_b_byte) + 9'(r_carry);

   // New sum byte enters from the top so byte 0 lands at the bottom after NBYTES steps
   assign w_acc_shift = (r_acc >> 8) | (W'(w_slice[7:0]) << (W - 8));

   // Next-state and datapath next values
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_carry_nxt = r_carry;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_acc_nxt   = r_acc;
      w_sum_nxt   = r_sum;
      w_cout_nxt  = r_cout;
`ifdef MP_ADD_SUB_EN
      w_sub_nxt   = r_sub;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt = S_ADD;
               w_a_nxt     = bus.a;
               w_b_nxt     = bus.b;
               w_cnt_nxt   = '0;
`ifdef MP_ADD_SUB_EN
               w_sub_nxt   = bus.sub;
               w_carry_nxt = bus.cin ^ bus.sub;
`else
               w_carry_nxt = bus.cin;
`endif
            end
         end
         S_ADD: begin
            w_a_nxt     = r_a >> 8;
            w_b_nxt     = r_b >> 8;
            w_acc_nxt   = w_acc_shift;
            w_carry_nxt = w_slice[8];
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               // Publish the result only on the final byte so sum/cout stay put during ADD
               w_state_nxt = S_DONE;
               w_sum_nxt   = w_acc_shift;
               w_cout_nxt  = w_slice[8];
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
`ifdef MP_ADD_SUB_EN
         r_sub       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_carry     <= w_carry_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_acc       <= w_acc_nxt;
         r_sum       <= w_sum_nxt;
         r_cout      <= w_cout_nxt;
         // Handshake flags are registered decodes of the next state
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt == S_DONE);
`ifdef MP_ADD_SUB_EN
         r_sub       <= w_sub_nxt;
`endif
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq
// Directed self-checking bench for mp_add_seq with NBYTES=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define MP_ADD_SUB_EN to also exercise subtraction.
module tb_mp_add_seq;
   localparam int unsigned NB = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   ncyc;

   mp_add_seq_if #(.NBYTES(NB)) ifc ();

   mp_add_seq #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ncyc++;
   endtask

   // Called at the falling edge right after acceptance; waits for the result
   task automatic wait_result(input string tag, input logic [31:0] es, input logic ec);
      int k;
      k = 0;
      check({tag, "_busy"}, 64'(ifc.in_ready), 64'(0));
      while (!ifc.out_valid && k < 20) begin
         tick();
         k++;
      end
      check({tag, "_lat"}, 64'(k), 64'(NB));
      check({tag, "_sum"}, 64'(ifc.sum), 64'(es));
      check({tag, "_cout"}, 64'(ifc.cout), 64'(ec));
   endtask

   // Full operation with out_ready high
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] es, input logic ec);
      ifc.a        = a;
      ifc.b        = b;
      ifc.cin      = ci;
      ifc.in_valid = 1'b1;
      check({tag, "_rdy"}, 64'(ifc.in_ready), 64'(1));
      tick();
      ifc.in_valid = 1'b0;
      wait_result(tag, es, ec);
      tick();
      check({tag, "_idle"}, 64'(ifc.in_ready), 64'(1));
      check({tag, "_ovl0"}, 64'(ifc.out_valid), 64'(0));
   endtask

   initial begin
      int  t1;
      int  t2;
      logic seen;
      n_checks      = 0;
      n_fail        = 0;
      ncyc          = 0;
      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.a         = '0;
      ifc.b         = '0;
      ifc.cin       = 1'b0;
      ifc.out_ready = 1'b1;
`ifdef MP_ADD_SUB_EN
      ifc.sub       = 1'b0;
`endif
      tick();
      tick();
      check("rst_in_ready", 64'(ifc.in_ready), 64'(1));
      check("rst_out_valid", 64'(ifc.out_valid), 64'(0));
      check("rst_sum", 64'(ifc.sum), 64'(0));
      check("rst_cout", 64'(ifc.cout), 64'(0));
      rst_n = 1'b1;
      tick();

      // Basic add and carry ripple
      run_op("basic",  32'h0000004A, 32'h00000053, 1'b0, 32'h0000009D, 1'b0);
      run_op("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
      run_op("byte1",  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);

      // Backpressure: result held, concurrent operand not accepted
      ifc.out_ready = 1'b0;
      ifc.a = 32'd1; ifc.b = 32'd2; ifc.cin = 1'b0; ifc.in_valid = 1'b1;
      check("bp_rdy", 64'(ifc.in_ready), 64'(1));
      tick();
      ifc.in_valid = 1'b0;
      wait_result("bp", 32'd3, 1'b0);
      ifc.a = 32'd7; ifc.b = 32'd0; ifc.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_ovl", 64'(ifc.out_valid), 64'(1));
         check("bp_hold_rdy", 64'(ifc.in_ready), 64'(0));
         check("bp_hold_sum", 64'(ifc.sum), 64'(3));
      end
      ifc.out_ready = 1'b1;
      tick();
      check("bp_rel_rdy", 64'(ifc.in_ready), 64'(1));
      check("bp_rel_ovl", 64'(ifc.out_valid), 64'(0));
      tick();
      ifc.in_valid = 1'b0;
      wait_result("bp2", 32'd7, 1'b0);
      tick();

      // Reset during the second ADD cycle discards the operation
      ifc.a = 32'h12345678; ifc.b = 32'd1; ifc.cin = 1'b0; ifc.in_valid = 1'b1;
      check("mr_rdy", 64'(ifc.in_ready), 64'(1));
      tick();
      ifc.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mr_in_ready", 64'(ifc.in_ready), 64'(1));
      check("mr_out_valid", 64'(ifc.out_valid), 64'(0));
      check("mr_sum", 64'(ifc.sum), 64'(0));
      check("mr_cout", 64'(ifc.cout), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | ifc.out_valid;
      end
      check("mr_no_result", 64'(seen), 64'(0));

      // Back-to-back with in_valid held high
      ifc.a = 32'h10; ifc.b = 32'h20; ifc.cin = 1'b0; ifc.in_valid = 1'b1;
      check("b2b_rdy1", 64'(ifc.in_ready), 64'(1));
      t1 = ncyc;
      tick();
      wait_result("b2b1", 32'h30, 1'b0);
      ifc.a = 32'h80000000; ifc.b = 32'h80000000;
      tick();
      check("b2b_rdy2", 64'(ifc.in_ready), 64'(1));
      t2 = ncyc;
      check("b2b_gap", 64'(t2 - t1), 64'(NB + 2));
      tick();
      ifc.in_valid = 1'b0;
      wait_result("b2b2", 32'h00000000, 1'b1);
      tick();

`ifdef MP_ADD_SUB_EN
      // Subtraction: cout=1 means no borrow
      ifc.sub = 1'b1;
      run_op("sub1", 32'h10, 32'h01, 1'b0, 32'h0000000F, 1'b1);
      run_op("sub2", 32'h00, 32'h01, 1'b0, 32'hFFFFFFFF, 1'b0);
      ifc.sub = 1'b0;
      run_op("sub0", 32'h10, 32'h01, 1'b0, 32'h00000011, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add sequencer: accepts two NBYTES-byte operands plus carry-in over a valid/ready handshake. It steps a single 8-bit add-with-carry slice across them, least-significant byte first, one byte per clock, propagating carry between bytes. It returns the full-width sum and final carry-out over a second valid/ready handshake. It is the controller that lets one 8-bit adder datapath serve arbitrary-width additions.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 1..16; W = 8*NBYTES.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand set presented.
- in_ready  output  1  sequencer can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in into byte 0.
- sub  input  1  subtract select; port present only with MP_ADD_SUB_EN.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  W  result, modulo 2^W.
- cout  output  1  carry out of byte NBYTES-1.

## Operation
- States: IDLE, ADD, DONE. Internal: byte counter (clog2(NBYTES) bits, min 1), carry register, operand shift registers, sum shift register.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b into shift registers; carry <= cin (or per sub rule); counter <= 0; go to ADD. Otherwise stay.
- ADD: in_ready=0.
  - Each cycle compute {c, s} = A[7:0] + B[7:0] + carry as 9 bits.
  - s shifts into sum register from the top byte; carry <= c; A/B shift right 8; counter++.
  - When counter == NBYTES-1 the edge also moves to DONE.
- DONE: out_valid=1; sum and cout stable. On out_ready, go to IDLE. Otherwise hold indefinitely.
- sum/cout hold their last value in IDLE and ADD; they are only meaningful while out_valid=1.
- Inputs a, b, cin, sub are ignored except on the acceptance edge.
- in_valid in ADD/DONE is not accepted; upstream must hold it.
- Reset outputs: in_ready=1 (state IDLE), out_valid=0, sum=0, cout=0. Reset also clears the internal counter, carry and shift registers.
- Reset asserted in any state, including mid-ADD or DONE with out_valid high: next edge is IDLE, and the pending operation is discarded with no result produced.

## Timing
- Acceptance edge T0. ADD occupies cycles T0+1..T0+NBYTES. out_valid rises at edge T0+NBYTES.
- Latency is NBYTES cycles from acceptance to out_valid; NBYTES=1 gives latency 1.
- Result handshake completes on the first edge with out_valid&&out_ready. in_ready rises on that same edge.
- Next acceptance is possible on the edge after that. Max throughput is one operation per NBYTES+2 cycles with out_ready tied high.
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.

## Configuration
- MP_ADD_SUB_EN defined:
  - sub port exists. With sub=1 at acceptance, B bytes are inverted as they are fed into the slice, and the initial carry = ~cin.
  - Result: sum = a - b - cin mod 2^W; cout = 1 means no borrow.
  - sub=0 behaves exactly as addition.
- MP_ADD_SUB_EN undefined: no sub port, no inverter logic; addition only, initial carry = cin.

## Test plan
- Basic add: NBYTES=4, out_ready=1, a=0x0000004A, b=0x00000053, cin=0 -> out_valid exactly 4 cycles after acceptance; sum=0x0000009D, cout=0.
- Carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1. Also a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0.
- Backpressure: a=1, b=2, cin=0 with out_ready=0 for 5 cycles after out_valid -> sum=3 held stable with out_valid=1 and in_ready=0 throughout. A concurrent in_valid with a=7 is not accepted until after out_ready is raised.
- Reset mid-op: accept a=0x12345678, b=1; drop rst_n for one edge at the second ADD cycle -> next cycle in_ready=1, out_valid=0, sum=0, cout=0; no result ever appears.
- Back-to-back: two ops queued with in_valid held high, out_ready=1 -> second acceptance exactly NBYTES+2 cycles after first; both results correct (0x10+0x20=0x30, 0x80000000+0x80000000 -> sum 0, cout=1).
- With MP_ADD_SUB_EN: sub=1, a=0x10, b=0x01, cin=0 -> sum=0x0000000F, cout=1. Then a=0, b=1, cin=0 -> sum=0xFFFFFFFF, cout=0.
